regfile_wb_queue: RTL and testbench

Write-back front-end for the 32×32 register file. Accepts write-back requests from the execute/memory stage over a valid/ready handshake, buffers them in a small in-order queue, and drains one entry per cycle into the register file as a one-hot write enable plus write data. It also bypasses the register-file read ports, so a read never returns a stale value while a write to the same register is still queued.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_wb_queue_if.sv | 21 ++
 rtl/regfile_dec.sv | 26 ++
 rtl/regfile_wb_queue.sv | 120 ++++++++++++
 tb/tb_regfile_wb_queue.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Constants and types shared by the register file and its write-back front-end.
//   REG_W      : register data width
//   ADDR_W     : register address width
//   NREG       : number of architectural registers
//   wb_entry_t : one queued write-back {addr, data}
package regfile_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// regfile_wb_queue_if
//   Valid/ready write-back request channel from execute/memory to the queue.
//   wb_valid : request present (master -> slave)
//   wb_ready : slave can accept (slave -> master)
//   wb_addr  : destination register (master -> slave)
//   wb_data  : destination data (master -> slave)
interface regfile_wb_queue_if
  import regfile_pkg::*;
#(
  parameter int W = REG_W
) ();

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [W-1:0]      wb_data;

  modport master (output wb_valid, output wb_addr, output wb_data, input  wb_ready);
  modport slave  (input  wb_valid, input  wb_addr, input  wb_data, output wb_ready);

endinterface

// File: rtl/regfile_dec.sv
// regfile_dec
//   Address-to-one-hot decoder for the register-file write enable.
//   addr : register address of the head entry
//   en   : pop condition; when low the output is all zero
//   dec  : one-hot write enable (NREG bits)
module regfile_dec
  import regfile_pkg::*;
#(
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [NREG-1:0]   dec
);

  // One-hot decode, forced to zero when no write is happening
  always_comb begin
    dec = {NREG{1'b0}};
    if (en) begin
      dec[addr] = 1'b1;
    end else begin
      dec = {NREG{1'b0}};
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//   In-order write-back queue in front of the register file with read bypass.
//   clk              : rising-edge clock
//   clr              : asynchronous active-low reset, empties the queue
//   wb               : write-back request channel (slave side)
//   rf_stall         : register file busy, no drain this cycle
//   rf_en / rf_write : one-hot write enable and data into the register file
//   readA / readB    : read addresses (also fed straight to the register file)
//   rf_outA/rf_outB  : raw register-file read data
//   outA / outB      : read data with queued writes bypassed in
//   level            : current queue occupancy
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = REG_W,
  parameter int NREG  = regfile_pkg::NREG
) (
  input  logic                     clk,
  input  logic                     clr,
  regfile_wb_queue_if.slave        wb,
  input  logic                     rf_stall,
  output logic [NREG-1:0]          rf_en,
  output logic [W-1:0]             rf_write,
  input  logic [ADDR_W-1:0]        readA,
  input  logic [ADDR_W-1:0]        readB,
  input  logic [W-1:0]             rf_outA,
  input  logic [W-1:0]             rf_outB,
  output logic [W-1:0]             outA,
  output logic [W-1:0]             outB,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   LEVEL_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   LEVEL_ZERO = {(PW+1){1'b0}};
  localparam logic [PW:0]   LEVEL_ONE  = (PW+1)'(1'b1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1'b1);

  wb_entry_t       fifo_r [DEPTH];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [PW:0]     level_r;
  logic            push_s;
  logic            enq_s;
  logic            pop_s;
  wb_entry_t       head_s;

  // Ready depends on occupancy only, so a full queue refuses even while popping
  assign wb.wb_ready = (level_r < LEVEL_FULL);
  assign push_s      = wb.wb_valid & wb.wb_ready;
  // Writes to register 0 complete the handshake but never occupy a slot
  assign enq_s       = push_s & (wb.wb_addr != {ADDR_W{1'b0}});
  assign pop_s       = (level_r != LEVEL_ZERO) & ~rf_stall;
  assign head_s      = fifo_r[head_r];
  assign level       = level_r;
  assign rf_write    = (level_r != LEVEL_ZERO) ? W'(head_s.data) : {W{1'b0}};

  regfile_dec #(.NREG(NREG)) u_dec (
    .addr (head_s.addr),
    .en   (pop_s),
    .dec  (rf_en)
  );

  // Queue storage written at the tail
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= {($bits(wb_entry_t)){1'b0}};
      end
    end else if (enq_s) begin
      fifo_r[tail_r] <= '{addr: wb.wb_addr, data: REG_W'(wb.wb_data)};
    end
  end

  // Head/tail pointers and occupancy counter
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      level_r <= LEVEL_ZERO;
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({enq_s, pop_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Read bypass: walk oldest to youngest so the youngest matching entry wins;
  // the head entry being written this cycle is still a valid match
  always_comb begin
    outA = rf_outA;
    outB = rf_outB;
    for (int k = 0; k < DEPTH; k++) begin
      outA = (((PW+1)'(k) < level_r) && (fifo_r[head_r + PW'(k)].addr == readA))
             ? W'(fifo_r[head_r + PW'(k)].data) : outA;
      outB = (((PW+1)'(k) < level_r) && (fifo_r[head_r + PW'(k)].addr == readB))
             ? W'(fifo_r[head_r + PW'(k)].data) : outB;
    end
    if (readA == {ADDR_W{1'b0}}) begin
      outA = {W{1'b0}};
    end else begin
      outA = outA;
    end
    if (readB == {ADDR_W{1'b0}}) begin
      outB = {W{1'b0}};
    end else begin
      outB = outB;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue
//   Directed bench for regfile_wb_queue. Expected register-file writes go into
//   a scoreboard queue as requests are pushed; a negedge monitor pops and
//   compares whenever rf_en is non-zero. Occupancy, ready and bypass values
//   are compared against hand-computed constants.
module tb_regfile_wb_queue;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        rf_stall;
  logic [31:0] rf_en;
  logic [31:0] rf_write;
  logic [4:0]  readA;
  logic [4:0]  readB;
  logic [31:0] rf_outA;
  logic [31:0] rf_outB;
  logic [31:0] outA;
  logic [31:0] outB;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  regfile_wb_queue_if #(.W(32)) wb ();

  regfile_wb_queue #(.DEPTH(4), .W(32), .NREG(32)) dut (
    .clk      (clk),
    .clr      (clr),
    .wb       (wb),
    .rf_stall (rf_stall),
    .rf_en    (rf_en),
    .rf_write (rf_write),
    .readA    (readA),
    .readB    (readB),
    .rf_outA  (rf_outA),
    .rf_outB  (rf_outB),
    .outA     (outA),
    .outB     (outB),
    .level    (level)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Push one request across one rising edge and record the write it should produce
  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wb.wb_valid = 1'b1;
    wb.wb_addr  = a;
    wb.wb_data  = d;
    @(posedge clk);
    #1;
    wb.wb_valid = 1'b0;
    if (a != 5'd0) exp_q.push_back({32'd1 << a, d});
  endtask

  // Scoreboard monitor: compare every register-file write against the queue head
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (rf_en !== 32'h0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got en %h data %h, expected no write", rf_en, rf_write);
      end else begin
        e = exp_q.pop_front();
        check("wr_en", rf_en, e[63:32]);
        check("wr_data", rf_write, e[31:0]);
      end
    end
  end

  initial begin
    clr = 1'b0;
    rf_stall = 1'b0;
    readA = 5'd3;
    readB = 5'd0;
    rf_outA = 32'h0000_1234;
    rf_outB = 32'h0000_0077;
    wb.wb_valid = 1'b0;
    wb.wb_addr = 5'd0;
    wb.wb_data = 32'h0;

    // Reset held, then released with no traffic
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_en", rf_en, 32'h0);
    check("rst_write", rf_write, 32'h0);
    check("rst_ready", 32'(wb.wb_ready), 32'd1);
    check("rst_outA", outA, 32'h0000_1234);
    check("rst_outB", outB, 32'h0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("idle_level", 32'(level), 32'd0);
    check("idle_ready", 32'(wb.wb_ready), 32'd1);
    check("idle_outA", outA, 32'h0000_1234);

    // Single write: visible in the cycle right after the push edge
    push(5'd5, 32'hDEAD_BEEF);
    check("single_level1", 32'(level), 32'd1);
    check("single_en", rf_en, 32'h0000_0020);
    check("single_write", rf_write, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    check("single_level0", 32'(level), 32'd0);

    // Fill while stalled
    rf_stall = 1'b1;
    push(5'd1, 32'hA000_0001);
    push(5'd2, 32'hA000_0002);
    push(5'd3, 32'hA000_0003);
    push(5'd4, 32'hA000_0004);
    check("full_level", 32'(level), 32'd4);
    check("full_ready", 32'(wb.wb_ready), 32'd0);
    check("stall_en", rf_en, 32'h0);
    check("stall_write", rf_write, 32'hA000_0001);
    rf_outA = 32'h0000_0099;
    #1;
    check("full_bypass_outA", outA, 32'hA000_0003);
    // Fifth push is refused and must not be written
    wb.wb_valid = 1'b1;
    wb.wb_addr = 5'd9;
    wb.wb_data = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
    wb.wb_valid = 1'b0;
    check("refused_level", 32'(level), 32'd4);
    rf_stall = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("drain_level", 32'(level), 32'd0);

    // Bypass picks the youngest of two writes to the same register
    rf_stall = 1'b1;
    push(5'd7, 32'h0000_0011);
    push(5'd7, 32'h0000_0022);
    readA = 5'd7;
    rf_outA = 32'h0000_0099;
    readB = 5'd0;
    rf_outB = 32'h0000_0055;
    #1;
    check("bypass_youngest_outA", outA, 32'h0000_0022);
    check("bypass_r0_outB", outB, 32'h0);
    readB = 5'd8;
    #1;
    check("bypass_miss_outB", outB, 32'h0000_0055);
    readB = 5'd7;
    #1;
    check("bypass_youngest_outB", outB, 32'h0000_0022);
    rf_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bypass_drained_outA", outA, 32'h0000_0099);
    check("bypass_drained_level", 32'(level), 32'd0);

    // Register 0: accepted but dropped
    check("r0_ready", 32'(wb.wb_ready), 32'd1);
    push(5'd0, 32'hFFFF_FFFF);
    check("r0_level", 32'(level), 32'd0);
    check("r0_en", rf_en, 32'h0);
    @(posedge clk);
    #1;
    check("r0_level_after", 32'(level), 32'd0);

    // Back-to-back pushes with concurrent pops keep occupancy at one
    push(5'd20, 32'hC000_0020);
    push(5'd21, 32'hC000_0021);
    check("pushpop_level_a", 32'(level), 32'd1);
    push(5'd22, 32'hC000_0022);
    check("pushpop_level_b", 32'(level), 32'd1);
    @(posedge clk);
    #1;
    check("pushpop_level_end", 32'(level), 32'd0);

    // Reset mid-operation between clock edges
    rf_stall = 1'b1;
    push(5'd10, 32'hB000_0010);
    push(5'd11, 32'hB000_0011);
    push(5'd12, 32'hB000_0012);
    check("midrst_level_before", 32'(level), 32'd3);
    #2;
    clr = 1'b0;
    exp_q.delete();
    rf_stall = 1'b0;
    #1;
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_en", rf_en, 32'h0);
    check("midrst_write", rf_write, 32'h0);
    check("midrst_ready", 32'(wb.wb_ready), 32'd1);
    check("midrst_outA", outA, 32'h0000_0099);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_level_after", 32'(level), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
